inst_cache: RTL
===============

INST_CACHE -- requirements
Module: inst_cache

Interface
REQ-001 Parameter INDEX_BITS, default 6, log2 of line count (64 lines).
REQ-002 Parameter LINE_WORDS, default 4, 32-bit words per line (16-byte line), fixed power of two.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 valid  input  1  fetch request from IF0/IF1 pipeline register, qualifies addr.
REQ-006 addr  input  32  fetch PC; bits [1:0] ignored.
REQ-007 ready  output  1  inst valid this cycle for current addr.
REQ-008 inst  output  32  fetched instruction, meaningful only when ready=1.
REQ-009 rd_req  output  1  refill request to memory side.
REQ-010 rd_addr  output  32  line-aligned refill address, low 4 bits zero.
REQ-011 rd_rdy  input  1  memory accepts rd_req in the same cycle.
REQ-012 ret_valid  input  1  one refill word present on ret_data.
REQ-013 ret_last  input  1  marks final refill word.
REQ-014 ret_data  input  32  refill word, delivered in ascending word order from offset 0.

Function
REQ-015 Address split: offset addr[3:2], index addr[9:4], tag addr[31:10]; direct-mapped, register-array storage (tag, valid bit, 4 data words per line).
REQ-016 Hit: valid=1, state IDLE, line valid, tag equal -> ready=1 and inst=word[offset] combinationally in the same cycle (0-cycle hit latency).
REQ-017 FSM states IDLE, MISS, REFILL; only IDLE serves hits.
REQ-018 IDLE -> MISS when valid=1 and lookup misses; latch miss tag/index into registers that cycle.
REQ-019 MISS: rd_req=1, rd_addr={latched tag, latched index, 4'b0}; held stable until rd_rdy=1; MISS -> REFILL on rd_req & rd_rdy.
REQ-020 REFILL: each ret_valid=1 writes ret_data into a line buffer at a 2-bit word counter, counter increments; ret_valid=0 cycles stall with no change.
REQ-021 On ret_valid & ret_last: write line buffer (with the final word) plus tag to latched index, set valid bit, counter to 0, -> IDLE.
REQ-022 First hit on refilled line occurs the cycle after the REFILL -> IDLE transition; miss-to-ready latency = 2 + memory handshake/return cycles.
REQ-023 ready=0 in MISS and REFILL regardless of addr.
REQ-024 valid dropping or addr changing during MISS/REFILL (pipeline flush/redirect) does not abort; refill completes and installs the line; new addr looked up on return to IDLE.
REQ-025 ret_last before 4 words counted: line installed with unreceived words unchanged; counter reset to 0.
REQ-026 ret_valid outside REFILL ignored; no storage change.
REQ-027 Refill to an index overwrites the previous line there (tag replaced, no victim handling; read-only cache).
REQ-028 valid=0 in IDLE: ready=0, no state change, rd_req=0.

Reset
REQ-029 rst low forces immediately: state IDLE, all valid bits 0, word counter 0, rd_req=0, rd_addr=0, ready=0; data/tag arrays need not clear.
REQ-030 rst asserted mid-MISS or mid-REFILL abandons the refill; the target line stays invalid after release.
REQ-031 First lookup after reset always misses.

Verification
REQ-032 After reset, valid=1 addr=0x1C000000 -> ready=0, next cycle rd_req=1 rd_addr=0x1C000000; rd_rdy=1; return 0x11,0x22,0x33,0x44 (last on 4th) -> cycle after, ready=1 inst=0x11; addr=0x1C00000C -> inst=0x44, same cycle.
REQ-033 Line filled at 0x1C000000, request 0x1C000400 (same index 0, different tag) -> miss, rd_addr=0x1C000400; afterwards 0x1C000000 misses again.
REQ-034 rd_rdy held 0 for 5 cycles in MISS -> rd_req and rd_addr constant throughout; no ret accepted before handshake.
REQ-035 Refill with ret_valid gaps (pattern 1,0,0,1,1,0,1) -> exactly 4 words stored in order, line valid once, ready only after last.
REQ-036 valid deasserted and addr changed to 0x1C000020 mid-REFILL -> original line installed; new addr then misses with rd_addr=0x1C000020.
REQ-037 rst pulsed low after 2 of 4 return words -> rd_req=0, ready=0 immediately; re-request same addr -> miss with fresh refill.

Source files
------------

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache with 0-cycle hits
// and a line-buffered refill from a word-serial memory port.
module inst_cache #(
   parameter int INDEX_BITS = 6,
   parameter int LINE_WORDS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid,
   input  logic [31:0] addr,
   output logic        ready,
   output logic [31:0] inst,
   output logic        rd_req,
   output logic [31:0] rd_addr,
   input  logic        rd_rdy,
   input  logic        ret_valid,
   input  logic        ret_last,
   input  logic [31:0] ret_data
);

   localparam int OFF_W  = $clog2(LINE_WORDS);
   localparam int BYTE_W = OFF_W + 2;
   localparam int TAG_W  = 32 - INDEX_BITS - BYTE_W;
   localparam int LINES  = 1 << INDEX_BITS;

   typedef enum logic [1:0] {
      IDLE,
      MISS,
      REFILL
   } state_e;

   state_e                  state_q, state_d;
   logic [LINES-1:0]        vld_q;
   logic [TAG_W-1:0]        tag_q  [LINES];
   logic [31:0]             data_q [LINES][LINE_WORDS];
   logic [31:0]             buf_q  [LINE_WORDS];
   logic [TAG_W-1:0]        mtag_q;
   logic [INDEX_BITS-1:0]   midx_q;
   logic [OFF_W-1:0]        cnt_q;
   logic [LINE_WORDS-1:0]   mask_q;

   logic [OFF_W-1:0]        off;
   logic [INDEX_BITS-1:0]   idx;
   logic [TAG_W-1:0]        tag;
   logic                    hit_raw;
   logic                    latch, take, install;
   logic                    unused_ok;

   assign off       = addr[BYTE_W-1:2];
   assign idx       = addr[BYTE_W+INDEX_BITS-1:BYTE_W];
   assign tag       = addr[31:BYTE_W+INDEX_BITS];
   assign unused_ok = ^addr[1:0];

   assign hit_raw = vld_q[idx] && (tag_q[idx] == tag);
   assign ready   = valid && (state_q == IDLE) && hit_raw;
   assign inst    = data_q[idx][off];
   assign rd_req  = (state_q == MISS);
   assign rd_addr = rd_req ? {mtag_q, midx_q, {BYTE_W{1'b0}}} : 32'h0;

   always_comb begin
      state_d = state_q;
      latch   = 1'b0;
      take    = 1'b0;
      install = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (valid && !hit_raw) begin
               state_d = MISS;
               latch   = 1'b1;
            end
         end
         MISS: begin
            if (rd_rdy) state_d = REFILL;
         end
         REFILL: begin
            if (ret_valid) begin
               take = 1'b1;
               if (ret_last) begin
                  install = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         vld_q   <= '0;
         mtag_q  <= '0;
         midx_q  <= '0;
         cnt_q   <= '0;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         if (latch) begin
            mtag_q <= tag;
            midx_q <= idx;
         end
         if (take) begin
            cnt_q  <= install ? '0 : cnt_q + 1'b1;
            mask_q <= install ? '0 : (mask_q | (LINE_WORDS'(1) << cnt_q));
         end
         if (install) vld_q[midx_q] <= 1'b1;
      end
   end

   // Storage needs no reset; only words actually returned are written back.
   always_ff @(posedge clk) begin
      if (take) buf_q[cnt_q] <= ret_data;
      if (install) begin
         tag_q[midx_q] <= mtag_q;
         for (int w = 0; w < LINE_WORDS; w++) begin
            if (cnt_q == OFF_W'(w))
               data_q[midx_q][w] <= ret_data;
            else if (mask_q[w])
               data_q[midx_q][w] <= buf_q[w];
         end
      end
   end

endmodule
